// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer: steps a run of consecutive challenges through the
// PUF subblock (reset, enable, race), synchronises the arbiter result and
// assembles a RESP_BITS-wide response presented over valid/ready.
// Optional build macro PUF_MAJORITY_VOTE_EN: race each challenge three times
// and shift in the majority bit.
module puf_challenge_sequencer #(
   parameter int unsigned RESP_BITS      = 32,
   parameter int unsigned RST_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 8388608
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [7:0]           base_challenge,
   output logic [7:0]           puf_challenge,
   output logic [31:0]          puf_enable,
   output logic                 puf_reset,
   input  logic                 puf_out,
   input  logic                 puf_done,
   output logic [RESP_BITS-1:0] response,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned AW = $clog2(RST_CYCLES + 1);
   localparam int unsigned BW = $clog2(RESP_BITS + 1);
   localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT_CYCLES);
   localparam logic [AW-1:0] ARM_LAST  = AW'(RST_CYCLES - 1);
   localparam logic [BW-1:0] BITS_V    = BW'(RESP_BITS);

   typedef enum logic [2:0] {IDLE, ARM, RUN, CAPTURE, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [1:0]    done_sync;
   logic [1:0]    out_sync;
   logic          done_s;
   logic          out_s;
   logic [AW-1:0] arm_cnt;
   logic [CW-1:0] cyc_cnt;
   logic [CW-1:0] cyc_inc;
   logic [BW-1:0] bit_cnt;
   logic [BW-1:0] bit_inc;
   logic          timed_out;
   logic          race_bit;
   logic          last_race;
   logic          shift_bit;
   logic          race_timeout;

`ifdef PUF_MAJORITY_VOTE_EN
   logic [1:0]    vote_cnt;
   logic [1:0]    tally;
`endif

   assign done_s       = done_sync[1];
   assign out_s        = out_sync[1];
   assign cyc_inc      = cyc_cnt + 1'b1;
   assign bit_inc      = bit_cnt + 1'b1;
   assign race_timeout = !done_s && (cyc_inc == TIMEOUT_V);
   // out_s is already valid in CAPTURE because it was launched with done.
   assign race_bit     = timed_out ? 1'b0 : out_s;

`ifdef PUF_MAJORITY_VOTE_EN
   // Majority of three: tally holds the ones from the first two races.
   assign last_race = (vote_cnt == 2'd2);
   assign shift_bit = tally[1] | (tally[0] & race_bit);
`else
   assign last_race = 1'b1;
   assign shift_bit = race_bit;
`endif

   // Subblock controls and status decoded straight from the state register.
   always_comb begin
      puf_reset  = (state != RUN);
      puf_enable = (state == RUN) ? '1 : '0;
      busy       = (state != IDLE);
      resp_valid = (state == DONE);
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = ARM;
         ARM:     if (arm_cnt == ARM_LAST) state_next = RUN;
         RUN:     if (done_s || race_timeout) state_next = CAPTURE;
         CAPTURE: begin
            if (last_race && (bit_inc == BITS_V)) state_next = DONE;
            else                                  state_next = ARM;
         end
         DONE:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Synchronisers, counters and response datapath.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         done_sync     <= '0;
         out_sync      <= '0;
         arm_cnt       <= '0;
         cyc_cnt       <= '0;
         bit_cnt       <= '0;
         timed_out     <= 1'b0;
         timeout_err   <= 1'b0;
         response      <= '0;
         puf_challenge <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
         vote_cnt      <= '0;
         tally         <= '0;
`endif
      end else begin
         done_sync <= {done_sync[0], puf_done};
         out_sync  <= {out_sync[0], puf_out};
         arm_cnt   <= (state == ARM) ? arm_cnt + 1'b1 : '0;
         cyc_cnt   <= (state == RUN) ? cyc_inc : '0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  puf_challenge <= base_challenge;
                  response      <= '0;
                  timeout_err   <= 1'b0;
                  timed_out     <= 1'b0;
                  bit_cnt       <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
                  vote_cnt      <= '0;
                  tally         <= '0;
`endif
               end
            end
            RUN: begin
               if (race_timeout) begin
                  timed_out   <= 1'b1;
                  timeout_err <= 1'b1;
               end
            end
            CAPTURE: begin
               timed_out <= 1'b0;
               if (last_race) begin
                  response      <= (response << 1) | RESP_BITS'(shift_bit);
                  bit_cnt       <= bit_inc;
                  puf_challenge <= puf_challenge + 8'd1;
               end
`ifdef PUF_MAJORITY_VOTE_EN
               if (last_race) begin
                  vote_cnt <= '0;
                  tally    <= '0;
               end else begin
                  vote_cnt <= vote_cnt + 2'd1;
                  tally    <= tally + {1'b0, race_bit};
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Testbench for puf_challenge_sequencer with a behavioural PUF subblock model
// and scoreboard queues of expected responses and raced challenges.
module tb_puf_challenge_sequencer;

   localparam int RB   = 8;
   localparam int RC   = 4;
   localparam int TO   = 100;
   localparam int RACE = 50;
`ifdef PUF_MAJORITY_VOTE_EN
   localparam int VOTES = 3;
`else
   localparam int VOTES = 1;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    base_challenge;
   logic [7:0]    puf_challenge;
   logic [31:0]   puf_enable;
   logic          puf_reset;
   logic          puf_out = 1'b0;
   logic          puf_done = 1'b0;
   logic [RB-1:0] response;
   logic          resp_valid;
   logic          resp_ready;
   logic          busy;
   logic          timeout_err;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int cyc    = 0;
   int start_cyc = 0;
   int n_runs = 0;
   int m_cnt  = 0;
   logic hang = 1'b0;
   logic [31:0] en_prev = '0;

   logic [7:0]    exp_chal_q[$];
   logic [7:0]    obs_chal_q[$];
   int            obs_time_q[$];
   logic [RB-1:0] exp_resp_q[$];

   always #5 clock = ~clock;

   puf_challenge_sequencer #(
      .RESP_BITS(RB),
      .RST_CYCLES(RC),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .base_challenge(base_challenge),
      .puf_challenge(puf_challenge),
      .puf_enable(puf_enable),
      .puf_reset(puf_reset),
      .puf_out(puf_out),
      .puf_done(puf_done),
      .response(response),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always @(posedge clock) cyc++;

   // Record challenge and cycle at every race start (enable rising).
   always @(negedge clock) begin
      if (puf_enable == '1 && en_prev != '1) begin
         obs_chal_q.push_back(puf_challenge);
         obs_time_q.push_back(cyc);
         n_runs++;
      end
      en_prev = puf_enable;
   end

   // Subblock model: done RACE cycles after enable, out stable with done.
   always @(negedge clock) begin
      if (puf_reset || puf_enable != '1) begin
         m_cnt = 0;
         puf_done = 1'b0;
         puf_out = 1'b0;
      end else begin
         m_cnt++;
         if (!hang && m_cnt == RACE) begin
`ifdef PUF_MAJORITY_VOTE_EN
            // odd challenge: 1,0,1 -> 1; even challenge: 0,0,1 -> 0
            puf_out = puf_challenge[0] ? (((n_runs - 1) % 3) != 1)
                                       : (((n_runs - 1) % 3) == 2);
`else
            puf_out = puf_challenge[0];
`endif
            puf_done = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input logic [7:0] base, input logic h);
      logic [RB-1:0] r;
      logic [7:0] c;
      hang = h;
      n_runs = 0;
      obs_chal_q.delete();
      obs_time_q.delete();
      exp_chal_q.delete();
      r = '0;
      for (int i = 0; i < RB; i++) begin
         c = base + 8'(i);
         for (int v = 0; v < VOTES; v++) exp_chal_q.push_back(c);
         r = {r[RB-2:0], h ? 1'b0 : c[0]};
      end
      exp_resp_q.push_back(r);
      base_challenge = base;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic finish_run(input logic [7:0] exp_final, input logic exp_to);
      int n;
      n = 0;
      while (!resp_valid && n < 6000) begin
         @(negedge clock);
         n++;
      end
      check("resp_valid_reached", 32'(resp_valid), 32'd1);
      check("response", 32'(response), 32'(exp_resp_q.pop_front()));
      check("timeout_err", 32'(timeout_err), 32'(exp_to));
      check("final_challenge", 32'(puf_challenge), 32'(exp_final));
      check("busy_in_done", 32'(busy), 32'd1);
      check("race_count", 32'(obs_chal_q.size()), 32'(exp_chal_q.size()));
      check("first_race_latency", 32'(obs_time_q[0] - start_cyc), 32'(RC + 1));
      if (exp_to)
         for (int i = 1; i < obs_time_q.size(); i++)
            check("timeout_race_spacing", 32'(obs_time_q[i] - obs_time_q[i-1]), 32'(TO + RC + 1));
      while (exp_chal_q.size() > 0 && obs_chal_q.size() > 0)
         check("race_challenge", 32'(obs_chal_q.pop_front()), 32'(exp_chal_q.pop_front()));
   endtask

   task automatic handshake();
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      check("valid_drop_after_ready", 32'(resp_valid), 32'd0);
      check("idle_after_ready", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [RB-1:0] held;
      logic stable;
      int n;
      reset = 1'b1;
      start = 1'b0;
      base_challenge = '0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_puf_reset", 32'(puf_reset), 32'd1);
      check("rst_puf_enable", puf_enable, 32'd0);
      check("rst_challenge", 32'(puf_challenge), 32'd0);
      check("rst_response", 32'(response), 32'd0);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Run A: base 10 -> 01010101, resting at 18
      start_run(8'h10, 1'b0);
      finish_run(8'h18, 1'b0);

      // DONE stall with a start pulse: nothing may move
      held = response;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         start = (i == 5);
         base_challenge = 8'h77;
         @(negedge clock);
         if (!resp_valid || response !== held) stable = 1'b0;
      end
      start = 1'b0;
      check("stall_stable", 32'(stable), 32'd1);
      check("stall_challenge", 32'(puf_challenge), 32'h18);
      check("stall_no_race", 32'(obs_chal_q.size()), 32'd0);
      handshake();

      // Run B: wrap FE, FF, 00 ...
      start_run(8'hFE, 1'b0);
      finish_run(8'h06, 1'b0);
      handshake();

      // Run C: done never arrives -> every race times out
      start_run(8'h03, 1'b1);
      finish_run(8'h0B, 1'b1);
      repeat (5) @(negedge clock);
      check("timeout_err_held", 32'(timeout_err), 32'd1);
      check("timeout_resp_held", 32'(response), 32'd0);
      handshake();

      // Run D: start clears timeout_err; reset mid-RUN at bit 3
      start_run(8'h40, 1'b0);
      check("start_clears_timeout", 32'(timeout_err), 32'd0);
      check("start_clears_response", 32'(response), 32'd0);
      n = 0;
      while (obs_chal_q.size() < 3 * VOTES + 1 && n < 6000) begin
         @(negedge clock);
         n++;
      end
      check("reached_bit3", 32'(obs_chal_q.size() >= 3 * VOTES + 1), 32'd1);
      repeat (10) @(negedge clock);
      check("midrun_response", 32'(response), 32'h02);
      reset = 1'b1;
      #1;
      check("async_puf_reset", 32'(puf_reset), 32'd1);
      check("async_puf_enable", puf_enable, 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      check("async_response", 32'(response), 32'd0);
      check("async_challenge", 32'(puf_challenge), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      exp_resp_q.delete();
      @(negedge clock);

      // Run E: clean restart after reset, base 21 -> 10101010
      start_run(8'h21, 1'b0);
      finish_run(8'h29, 1'b0);
      handshake();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
